// File: rtl/breath_pwm_pkg.sv
// Shared constants and timing helper for the breathing-PWM LED blocks.
// The sequencer and benches use ramp_clocks to predict the STT cadence.
package breath_pkg;

   localparam int DEF_PWM_BITS = 8;
   localparam int DEF_PRESCALE = 1;
   localparam int DEF_DWELL    = 4;

   // Clocks per full ramp: prescale * period ticks * dwell periods * level count.
   function automatic longint ramp_clocks(input int bits, input int pre, input int dwell);
      longint levels;
      levels = longint'(1) << bits;
      return longint'(pre) * levels * longint'(dwell) * levels;
   endfunction

endpackage

// File: rtl/breath_pwm_if.sv
// Link between the colour sequencer (master) and one breathing-PWM slot (slave).
interface breath_pwm_if;

   logic DIR;
   logic STT;
   logic PWM_OUT;

   modport master (output DIR, input STT, input PWM_OUT);
   modport slave  (input DIR, output STT, output PWM_OUT);

endinterface

// File: rtl/breath_pwm_tick_div.sv
// Clock-enable divider: tick is high one cycle out of every PRESCALE.
module tick_div #(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic RST_N,
   output logic tick
);

   logic [15:0] r_pc;

   assign tick = (r_pc == 16'(PRESCALE - 1));

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_pc <= '0;
      end else if (tick) begin
         r_pc <= '0;
      end else begin
         r_pc <= r_pc + 16'd1;
      end
   end

endmodule

// File: rtl/breath_pwm.sv
// Breathing-PWM generator: fixed-frequency PWM whose duty ramps through every
// level, with a one-cycle STT strobe at the end of each complete ramp.
module breath_pwm
   import breath_pkg::*;
#(
   parameter int PWM_BITS   = DEF_PWM_BITS,
   parameter int PRESCALE   = DEF_PRESCALE,
   parameter int DWELL      = DEF_DWELL,
   parameter int ACTIVE_LOW = 1
) (
   input  logic         CLK,
   input  logic         RST_N,
   breath_pwm_if.slave  bus
);

   localparam logic [PWM_BITS-1:0] LMAX = '1;
   localparam logic                OFF  = (ACTIVE_LOW != 0);

   logic [PWM_BITS-1:0] r_cnt;
   logic [15:0]         r_dwell;
   logic [PWM_BITS-1:0] r_level;
   logic                r_dir;
   logic                r_stt;
   logic                r_pwm;

   logic                w_tick;
   logic                w_pend;
   logic                w_dend;
   logic [PWM_BITS-1:0] w_bright;
   logic                w_on;

   tick_div #(
      .PRESCALE (PRESCALE)
   ) u_tick_div (
      .CLK   (CLK),
      .RST_N (RST_N),
      .tick  (w_tick)
   );

   assign w_pend = w_tick && (r_cnt == LMAX);
   assign w_dend = w_pend && (r_dwell == 16'(DWELL - 1));

   // r_dir and r_level only move at pend, so bright is stable within a period.
   assign w_bright = r_dir ? r_level : (LMAX - r_level);
   assign w_on     = (r_cnt < w_bright);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_cnt   <= '0;
         r_dwell <= '0;
         r_level <= '0;
         r_dir   <= bus.DIR;
         r_stt   <= 1'b0;
         r_pwm   <= OFF;
      end else begin
         if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_pend) begin
            r_dir   <= bus.DIR;
            r_dwell <= w_dend ? 16'd0 : (r_dwell + 16'd1);
         end
         if (w_dend) begin
            r_level <= r_level + 1'b1;
         end
         r_stt <= w_dend && (r_level == LMAX);
         r_pwm <= w_on ^ OFF;
      end
   end

   assign bus.STT     = r_stt;
   assign bus.PWM_OUT = r_pwm;

endmodule

// File: tb/tb_breath_pwm.sv
// Directed bench for breath_pwm: expected PWM/STT values are queued per cycle
// from a closed-form timing model and compared after each clock edge.
module tb_breath_pwm;

   logic clk;
   logic rst_a, rst_b, rst_c;

   breath_pwm_if if_a ();
   breath_pwm_if if_b ();
   breath_pwm_if if_c ();

   breath_pwm #(.PWM_BITS(3), .PRESCALE(1), .DWELL(1), .ACTIVE_LOW(1)) dut_a (
      .CLK(clk), .RST_N(rst_a), .bus(if_a));
   breath_pwm #(.PWM_BITS(3), .PRESCALE(1), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
      .CLK(clk), .RST_N(rst_b), .bus(if_b));
   breath_pwm #(.PWM_BITS(2), .PRESCALE(3), .DWELL(2), .ACTIVE_LOW(1)) dut_c (
      .CLK(clk), .RST_N(rst_c), .bus(if_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int    ch;
      string tag;
      logic  exp;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic obs_of(input int ch);
      case (ch)
         0: return if_a.PWM_OUT;
         1: return if_a.STT;
         2: return if_b.PWM_OUT;
         3: return if_b.STT;
         4: return if_c.PWM_OUT;
         5: return if_c.STT;
         default: return 1'bx;
      endcase
   endfunction

   // Active-low pin level expected t clocks after reset release.
   function automatic logic mdl_pwm(input int bits, input int pre, input int dw,
                                    input int t, input bit dir);
      int levels, cnt, lvl, br;
      levels = 1 << bits;
      cnt    = (t / pre) % levels;
      lvl    = (t / (pre * levels * dw)) % levels;
      br     = dir ? lvl : (levels - 1 - lvl);
      return (cnt < br) ? 1'b0 : 1'b1;
   endfunction

   task automatic push(input int ch, input string tag, input logic e);
      exp_t x;
      x.ch  = ch;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic step_and_check();
      exp_t x;
      logic o;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         o = obs_of(x.ch);
         checks++;
         assert (o === x.exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", x.tag, o, x.exp);
         end
      end
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      if_a.DIR = 1'b1; if_b.DIR = 1'b0; if_c.DIR = 1'b1;

      // Held reset: outputs idle (off = 1), no strobe.
      for (int i = 0; i < 5; i++) begin
         push(0, $sformatf("rst_A_pwm c=%0d", i), 1'b1);
         push(1, $sformatf("rst_A_stt c=%0d", i), 1'b0);
         push(2, $sformatf("rst_B_pwm c=%0d", i), 1'b1);
         push(3, $sformatf("rst_B_stt c=%0d", i), 1'b0);
         push(4, $sformatf("rst_C_pwm c=%0d", i), 1'b1);
         push(5, $sformatf("rst_C_stt c=%0d", i), 1'b0);
         step_and_check();
      end
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Up ramp (A), down ramp (B), prescale/dwell (C), all released together.
      for (int n = 1; n <= 192; n++) begin
         push(0, $sformatf("up_A_pwm n=%0d", n),   mdl_pwm(3, 1, 1, n - 1, 1'b1));
         push(1, $sformatf("up_A_stt n=%0d", n),   logic'(n % 64 == 0));
         push(2, $sformatf("dn_B_pwm n=%0d", n),   mdl_pwm(3, 1, 1, n - 1, 1'b0));
         push(3, $sformatf("dn_B_stt n=%0d", n),   logic'(n % 64 == 0));
         push(4, $sformatf("pre_C_pwm n=%0d", n),  mdl_pwm(2, 3, 2, n - 1, 1'b1));
         push(5, $sformatf("pre_C_stt n=%0d", n),  logic'(n % 96 == 0));
         step_and_check();
      end

      // DIR 1->0 at cnt=2 of period 4: takes effect from period 5.
      rst_a = 1'b0; if_a.DIR = 1'b1;
      push(0, "dirchg_rst_pwm", 1'b1);
      push(1, "dirchg_rst_stt", 1'b0);
      step_and_check();
      rst_a = 1'b1;
      for (int n = 1; n <= 64; n++) begin
         if (n == 35) if_a.DIR = 1'b0;
         push(0, $sformatf("dirchg_A_pwm n=%0d", n),
              mdl_pwm(3, 1, 1, n - 1, ((n - 1) / 8 >= 5) ? 1'b0 : 1'b1));
         push(1, $sformatf("dirchg_A_stt n=%0d", n), logic'(n % 64 == 0));
         step_and_check();
      end

      // Reset mid-ramp at cycle 40 aborts the ramp; timing restarts from release.
      rst_a = 1'b0; if_a.DIR = 1'b1;
      push(0, "midrst_init_pwm", 1'b1);
      push(1, "midrst_init_stt", 1'b0);
      step_and_check();
      rst_a = 1'b1;
      for (int n = 1; n <= 39; n++) begin
         push(0, $sformatf("midrst_pre_pwm n=%0d", n), mdl_pwm(3, 1, 1, n - 1, 1'b1));
         push(1, $sformatf("midrst_pre_stt n=%0d", n), 1'b0);
         step_and_check();
      end
      rst_a = 1'b0;
      push(0, "midrst_edge_pwm", 1'b1);
      push(1, "midrst_edge_stt", 1'b0);
      step_and_check();
      rst_a = 1'b1;
      for (int n = 1; n <= 70; n++) begin
         push(0, $sformatf("midrst_post_pwm n=%0d", n), mdl_pwm(3, 1, 1, n - 1, 1'b1));
         push(1, $sformatf("midrst_post_stt n=%0d", n), logic'(n % 64 == 0));
         step_and_check();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
